// File: rtl/four_bit_restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and the
// helper that sizes the step counter from the operand width.
package four_bit_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // The counter has to hold the value WIDTH itself, hence WIDTH+1.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/four_bit_restoring_divider_subtractor.sv
// Ripple-borrow subtractor: the adder's full_adder cells with b inverted and
// the carry-in forced high, so a missing carry-out is a borrow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module four_bit_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow_out = ~carry[WIDTH];

endmodule

// File: rtl/four_bit_restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
module four_bit_restoring_divider
  import four_bit_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = count_width(WIDTH);

  div_state_t       state;
  div_state_t       state_next;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] div_reg;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             restore;
  logic             accept;

  assign accept      = (state == ST_IDLE) && start;
  assign rem_shifted = {rem_reg, quo_reg[WIDTH-1]};

  four_bit_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a          (rem_shifted),
    .b          ({1'b0, div_reg}),
    .diff       (trial),
    .borrow_out (borrow)
  );

  // A set top bit in the difference can only accompany a borrow, since the
  // shifted remainder never reaches twice the divisor.
  assign restore = borrow | trial[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (divisor != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (count == CW'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Working registers: load on accept, then shift/subtract once per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg <= '0;
      quo_reg <= '0;
      div_reg <= '0;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            div_reg <= divisor;
            count   <= CW'(WIDTH);
          end
        end
        ST_RUN: begin
          rem_reg <= restore ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], ~restore};
          count   <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Results are held until the next completion; busy survives a same-edge
  // re-accept so back-to-back operations keep it high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      if (accept) begin
        busy     <= 1'b1;
        div_zero <= 1'b0;
      end
      if (state == ST_DONE) begin
        done <= 1'b1;
        if (div_reg == '0) begin
          quotient  <= '1;
          remainder <= quo_reg;
          div_zero  <= 1'b1;
        end else begin
          quotient  <= quo_reg;
          remainder <= rem_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_four_bit_restoring_divider.sv
// Self-checking bench for four_bit_restoring_divider: directed cases with
// literal expectations plus an arithmetic reference checked on every done.
module tb_four_bit_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  int total;
  int bad;
  int done_count;
  int req_count;

  int exp_q[$];
  int exp_r[$];
  int exp_z[$];

  four_bit_restoring_divider #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference result from plain integer division, zero divisor handled apart.
  task automatic push_model(input int a, input int b);
    if (b == 0) begin
      exp_q.push_back(15);
      exp_r.push_back(a);
      exp_z.push_back(1);
    end else begin
      exp_q.push_back(a / b);
      exp_r.push_back(a % b);
      exp_z.push_back(0);
    end
    req_count++;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending request");
      end else begin
        check_output("model_quotient", quotient, exp_q.pop_front());
        check_output("model_remainder", remainder, exp_r.pop_front());
        check_output("model_div_zero", div_zero, exp_z.pop_front());
        check_output("model_busy_with_done", busy, 1);
      end
    end
  end

  // Issue one request from an idle DUT and time it: lat counts edges after
  // the accepting edge until done is seen, bc counts cycles with busy high.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b,
                                output int lat, output int bc);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    push_model(a, b);
    #1;
    start = 1'b0;
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done within 20 edges, expected done");
    end
    @(posedge clk);
    #1;
    check_output("busy_after_done", busy, 0);
    check_output("done_single_pulse", done, 0);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    total      = 0;
    bad        = 0;
    done_count = 0;
    req_count  = 0;
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;

    #1;
    check_output("reset_quotient", quotient, 0);
    check_output("reset_remainder", remainder, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_div_zero", div_zero, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed cases");
    apply_stimulus(4'd13, 4'd3, lat, bc);
    check_output("lat_13_3", lat, 5);
    check_output("busy_cycles_13_3", bc, 6);
    check_output("q_13_3", quotient, 4);
    check_output("r_13_3", remainder, 1);
    check_output("z_13_3", div_zero, 0);

    apply_stimulus(4'd15, 4'd15, lat, bc);
    check_output("lat_15_15", lat, 5);
    check_output("q_15_15", quotient, 1);
    check_output("r_15_15", remainder, 0);

    apply_stimulus(4'd7, 4'd9, lat, bc);
    check_output("lat_7_9", lat, 5);
    check_output("q_7_9", quotient, 0);
    check_output("r_7_9", remainder, 7);

    apply_stimulus(4'd0, 4'd5, lat, bc);
    check_output("lat_0_5", lat, 5);
    check_output("q_0_5", quotient, 0);
    check_output("r_0_5", remainder, 0);

    apply_stimulus(4'd9, 4'd0, lat, bc);
    check_output("lat_9_0", lat, 1);
    check_output("q_9_0", quotient, 15);
    check_output("r_9_0", remainder, 9);
    check_output("z_9_0", div_zero, 1);

    apply_stimulus(4'd8, 4'd2, lat, bc);
    check_output("lat_8_2", lat, 5);
    check_output("q_8_2", quotient, 4);
    check_output("r_8_2", remainder, 0);
    check_output("z_8_2", div_zero, 0);

    $display("[TB] start pulsed during RUN");
    seen     = done_count;
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    push_model(13, 3);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    dividend = 4'd6;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_output("ignored_start_done_count", done_count - seen, 1);
    check_output("ignored_start_q", quotient, 4);
    check_output("ignored_start_r", remainder, 1);
    check_output("ignored_start_busy", busy, 0);

    $display("[TB] reset during RUN");
    seen     = done_count;
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("abort_quotient", quotient, 0);
    check_output("abort_remainder", remainder, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_div_zero", div_zero, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_output("abort_no_done", done_count - seen, 0);
    apply_stimulus(4'd10, 4'd4, lat, bc);
    check_output("lat_10_4", lat, 5);
    check_output("q_10_4", quotient, 2);
    check_output("r_10_4", remainder, 2);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply_stimulus(4'(a), 4'(b), lat, bc);
        check_output("sweep_latency", lat, (b == 0) ? 1 : 5);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check_output("done_vs_requests", done_count, req_count);
    check_output("model_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
